hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline hazard and sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB). It takes the ID-stage instruction's decoded control bits (rs2_imm_sel, reg_w_en, mem_w_en, mem_alu_sel class) and register indices, and tracks the destination of every in-flight instruction in EX and MEM. From that state it drives load-use stalls, bubble insertion and flushes, and registers forwarding selects for the EX stage. It also counts stall cycles for performance debug.

## Interface
Parameters:
- REG_AW, 5, register index width
- CNT_W, 16, stall counter width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- id_valid  in  1  ID stage holds a real instruction
- id_rs1  in  REG_AW  ID source register 1
- id_rs2  in  REG_AW  ID source register 2
- id_use_rs1  in  1  instruction reads rs1
- id_use_rs2  in  1  instruction reads rs2 (0 for I-type/Load, where rs2_imm_sel=1 and not store)
- id_rd  in  REG_AW  ID destination register
- id_reg_w_en  in  1  ID instruction writes the register file
- id_is_load  in  1  ID instruction is a load (reg_w_en=1, mem_alu_sel=0)
- flush  in  1  taken branch/jump resolved in EX; kill IF and ID contents
- mem_busy  in  1  data memory not ready; whole pipeline freezes
- pc_hold  out  1  hold PC and IF/ID register this cycle
- ex_bubble  out  1  load NOP (all write enables 0) into ID/EX at next edge
- pipe_freeze  out  1  hold every pipeline register this cycle
- fwd_rs1_sel  out  2  EX operand 1 source: 00 regfile, 01 MEM-stage ALU result, 10 WB-stage write data
- fwd_rs2_sel  out  2  same for operand 2
- stall_cnt  out  CNT_W  saturating count of cycles with pc_hold=1

## Operation
- Internal state: per stage S in {EX, MEM}, registers S_v, S_rd, S_wen, S_load describing the instruction in that stage.
- Register file is write-first. A WB-stage write is visible to the same-cycle ID read, so only EX and MEM matches need forwarding.
- Match rule: EX_match_rsN = id_valid & id_use_rsN & EX_v & EX_wen & (EX_rd == id_rsN) & (id_rsN != 0). MEM_match is analogous. x0 never matches.
- Load-use: luse = (EX_match_rs1 | EX_match_rs2) & EX_load.
- Combinational outputs, in priority order:
  - pipe_freeze = mem_busy. Forces pc_hold=0, ex_bubble=0. No state updates. stall_cnt does not count.
  - Else flush=1: ex_bubble=1, pc_hold=0, luse ignored.
  - Else luse=1: pc_hold=1, ex_bubble=1.
  - Else pc_hold=0, ex_bubble=0.
- Stage advance (when not frozen):
  - MEM <= EX.
  - EX <= bubble (v=0, wen=0, load=0) if ex_bubble. Otherwise EX <= {id_valid, id_rd, id_reg_w_en & id_valid, id_is_load & id_valid}.
- Forward select registration (when not frozen), per operand N:
  - If ex_bubble: fwd_rsN_sel <= 00.
  - Else if EX_match_rsN: <= 01 (producer moves to MEM). Cannot be a load here, because luse would have stalled.
  - Else if MEM_match_rsN: <= 10 (producer moves to WB; covers the load result after a one-cycle stall).
  - Else: <= 00.
  - Youngest producer wins: EX match has priority over MEM match.
- stall_cnt: +1 on every non-frozen cycle with pc_hold=1. Saturates at all-ones.

## Timing
- Reset (rst_n=0 at edge): EX_v, MEM_v, all wen/load bits = 0; fwd_rs1_sel = fwd_rs2_sel = 00; stall_cnt = 0. During reset, pc_hold, ex_bubble and pipe_freeze evaluate from cleared state and so read 0 unless mem_busy or flush.
- Reset mid-operation discards all tracked producers. No stall is raised by pre-reset instructions.
- pc_hold, ex_bubble and pipe_freeze are combinational, valid in the same cycle as ID inputs.
- fwd_*_sel are registered and valid during the cycle the instruction occupies EX.
- Load-use costs exactly 1 stall cycle. In the following cycle the load is in MEM, luse=0, and the consumer enters EX with sel=10.
- mem_busy for k cycles delays everything by exactly k cycles. Forwarding selects stay held and valid throughout.
- flush together with luse: flush wins, 0 stall cycles, stall_cnt unchanged.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with random inputs → fwd sels 00, stall_cnt 0, no pc_hold after release with id_valid=0.
- ALU chain: add x5 (rd=5, wen) then next ID reads rs1=5 → no stall, fwd_rs1_sel=01 in consumer's EX cycle. With one independent instruction between them → 10.
- Load-use: load rd=7 then consumer rs2=7 → pc_hold=1 and ex_bubble=1 for exactly 1 cycle, then fwd_rs2_sel=10, stall_cnt=1.
- x0 and non-use: producer rd=0, or consumer with id_use_rs2=0 matching rs2 → sels 00, no stall.
- Double match: EX and MEM both write rd=3, consumer reads x3 → sel=01. Load rd=3 in EX → stall.
- Freeze/flush: mem_busy held 3 cycles during load-use → no state change and stall_cnt unchanged; flush with luse → ex_bubble=1, pc_hold=0. Saturation: preload near max → stall_cnt holds 0xFFFF.

Source files
------------

// File: rtl/hazard_controller_if.sv
// Bundle between the ID-stage decode and the hazard controller: ID
// instruction fields and pipeline commands in, stall/bubble/forward controls out.
interface hazard_controller_if #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
);
   logic              id_valid;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_use_rs1;
   logic              id_use_rs2;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_w_en;
   logic              id_is_load;
   logic              flush;
   logic              mem_busy;
   logic              pc_hold;
   logic              ex_bubble;
   logic              pipe_freeze;
   logic [1:0]        fwd_rs1_sel;
   logic [1:0]        fwd_rs2_sel;
   logic [CNT_W-1:0]  stall_cnt;

   modport master (
      output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      output id_rd, id_reg_w_en, id_is_load, flush, mem_busy,
      input  pc_hold, ex_bubble, pipe_freeze, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
      input  id_rd, id_reg_w_en, id_is_load, flush, mem_busy,
      output pc_hold, ex_bubble, pipe_freeze, fwd_rs1_sel, fwd_rs2_sel, stall_cnt
   );
endinterface

// File: rtl/hazard_controller.sv
// Hazard controller for the 5-stage pipeline: tracks EX/MEM destinations,
// raises load-use stalls, bubbles and flushes, registers EX forwarding
// selects, and counts stall cycles (saturating).
module hazard_controller #(
   parameter int REG_AW = 5,
   parameter int CNT_W  = 16
) (
   input logic                clk,
   input logic                rst_n,
   hazard_controller_if.slave bus
);
   // The MEM stage needs no load flag: a load in MEM is forwarded from WB
   // one cycle later like any other result.
   logic              ex_v;
   logic              ex_wen;
   logic              ex_load;
   logic [REG_AW-1:0] ex_rd;
   logic              mem_v;
   logic              mem_wen;
   logic [REG_AW-1:0] mem_rd;

   logic [1:0]        fwd_rs1_q;
   logic [1:0]        fwd_rs2_q;
   logic [CNT_W-1:0]  stall_cnt_q;

   logic              ex_match_rs1;
   logic              ex_match_rs2;
   logic              mem_match_rs1;
   logic              mem_match_rs2;
   logic              luse;
   logic              pc_hold;
   logic              ex_bubble;

   // Compare the ID sources against in-flight writers; x0 never matches.
   always_comb begin
      ex_match_rs1  = bus.id_valid && bus.id_use_rs1 && ex_v && ex_wen &&
                      (ex_rd == bus.id_rs1) && (bus.id_rs1 != '0);
      ex_match_rs2  = bus.id_valid && bus.id_use_rs2 && ex_v && ex_wen &&
                      (ex_rd == bus.id_rs2) && (bus.id_rs2 != '0);
      mem_match_rs1 = bus.id_valid && bus.id_use_rs1 && mem_v && mem_wen &&
                      (mem_rd == bus.id_rs1) && (bus.id_rs1 != '0);
      mem_match_rs2 = bus.id_valid && bus.id_use_rs2 && mem_v && mem_wen &&
                      (mem_rd == bus.id_rs2) && (bus.id_rs2 != '0);
      luse          = (ex_match_rs1 || ex_match_rs2) && ex_load;
   end

   // Pipeline control in priority order: memory freeze, then flush, then load-use.
   always_comb begin
      pc_hold   = 1'b0;
      ex_bubble = 1'b0;
      if (bus.mem_busy) begin
         pc_hold   = 1'b0;
         ex_bubble = 1'b0;
      end else if (bus.flush) begin
         ex_bubble = 1'b1;
      end else if (luse) begin
         pc_hold   = 1'b1;
         ex_bubble = 1'b1;
      end
   end

   assign bus.pc_hold     = pc_hold;
   assign bus.ex_bubble   = ex_bubble;
   assign bus.pipe_freeze = bus.mem_busy;
   assign bus.fwd_rs1_sel = fwd_rs1_q;
   assign bus.fwd_rs2_sel = fwd_rs2_q;
   assign bus.stall_cnt   = stall_cnt_q;

   // Advance the EX/MEM destination trackers, inserting a bubble when asked.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_v    <= 1'b0;
         ex_wen  <= 1'b0;
         ex_load <= 1'b0;
         ex_rd   <= '0;
         mem_v   <= 1'b0;
         mem_wen <= 1'b0;
         mem_rd  <= '0;
      end else if (!bus.mem_busy) begin
         mem_v   <= ex_v;
         mem_wen <= ex_wen;
         mem_rd  <= ex_rd;
         if (ex_bubble) begin
            ex_v    <= 1'b0;
            ex_wen  <= 1'b0;
            ex_load <= 1'b0;
            ex_rd   <= '0;
         end else begin
            ex_v    <= bus.id_valid;
            ex_wen  <= bus.id_reg_w_en && bus.id_valid;
            ex_load <= bus.id_is_load && bus.id_valid;
            ex_rd   <= bus.id_rd;
         end
      end
   end

   // Register forwarding selects for the instruction entering EX; the
   // youngest producer (currently in EX, moving to MEM) wins.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fwd_rs1_q <= 2'b00;
         fwd_rs2_q <= 2'b00;
      end else if (!bus.mem_busy) begin
         if (ex_bubble)          fwd_rs1_q <= 2'b00;
         else if (ex_match_rs1)  fwd_rs1_q <= 2'b01;
         else if (mem_match_rs1) fwd_rs1_q <= 2'b10;
         else                    fwd_rs1_q <= 2'b00;

         if (ex_bubble)          fwd_rs2_q <= 2'b00;
         else if (ex_match_rs2)  fwd_rs2_q <= 2'b01;
         else if (mem_match_rs2) fwd_rs2_q <= 2'b10;
         else                    fwd_rs2_q <= 2'b00;
      end
   end

   // Saturating count of stalled cycles for performance debug.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_q <= '0;
      end else if (!bus.mem_busy && pc_hold && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller: a table of per-cycle vectors with
// hand-computed results, plus sequences for reset and counter saturation.
module tb_hazard_controller;
   logic clk;
   logic rst_n;

   int tests_run;
   int tests_failed;

   hazard_controller_if #(.REG_AW(5), .CNT_W(16)) hif();
   hazard_controller_if #(.REG_AW(5), .CNT_W(4))  sif();

   hazard_controller #(.REG_AW(5), .CNT_W(16)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (hif.slave)
   );

   hazard_controller #(.REG_AW(5), .CNT_W(4)) sat_dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (sif.slave)
   );

   assign sif.id_valid    = hif.id_valid;
   assign sif.id_rs1      = hif.id_rs1;
   assign sif.id_rs2      = hif.id_rs2;
   assign sif.id_use_rs1  = hif.id_use_rs1;
   assign sif.id_use_rs2  = hif.id_use_rs2;
   assign sif.id_rd       = hif.id_rd;
   assign sif.id_reg_w_en = hif.id_reg_w_en;
   assign sif.id_is_load  = hif.id_is_load;
   assign sif.flush       = hif.flush;
   assign sif.mem_busy    = hif.mem_busy;

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       w;
      logic       ld;
      logic       fl;
      logic       mb;
      logic       ph;
      logic       eb;
      logic [1:0] f1;
      logic [1:0] f2;
      logic [15:0] cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                               input logic u1, input logic u2, input logic [4:0] rd,
                               input logic w, input logic ld, input logic fl, input logic mb,
                               input logic ph, input logic eb, input logic [1:0] f1,
                               input logic [1:0] f2, input logic [15:0] cnt);
      vec_t t;
      t.v = v;   t.rs1 = rs1; t.rs2 = rs2; t.u1 = u1; t.u2 = u2;
      t.rd = rd; t.w = w;     t.ld = ld;   t.fl = fl; t.mb = mb;
      t.ph = ph; t.eb = eb;   t.f1 = f1;   t.f2 = f2; t.cnt = cnt;
      return t;
   endfunction

   task automatic check_output(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic apply_stimulus(input vec_t t);
      hif.id_valid    = t.v;
      hif.id_rs1      = t.rs1;
      hif.id_rs2      = t.rs2;
      hif.id_use_rs1  = t.u1;
      hif.id_use_rs2  = t.u2;
      hif.id_rd       = t.rd;
      hif.id_reg_w_en = t.w;
      hif.id_is_load  = t.ld;
      hif.flush       = t.fl;
      hif.mem_busy    = t.mb;
   endtask

   // One cycle: drive, check combinational controls mid-cycle, then check
   // registered outputs just after the edge.
   task automatic run_vec(input vec_t t, input string tag);
      apply_stimulus(t);
      @(negedge clk);
      check_output({tag, " pc_hold"},     16'(hif.pc_hold),     16'(t.ph));
      check_output({tag, " ex_bubble"},   16'(hif.ex_bubble),   16'(t.eb));
      check_output({tag, " pipe_freeze"}, 16'(hif.pipe_freeze), 16'(t.mb));
      @(posedge clk);
      #1;
      check_output({tag, " fwd_rs1_sel"}, 16'(hif.fwd_rs1_sel), 16'(t.f1));
      check_output({tag, " fwd_rs2_sel"}, 16'(hif.fwd_rs2_sel), 16'(t.f2));
      check_output({tag, " stall_cnt"},   hif.stall_cnt,        t.cnt);
   endtask

   // Main test sequence.
   initial begin
      vec_t idle;
      tests_run    = 0;
      tests_failed = 0;
      idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0);

      //        v rs1 rs2 u1 u2 rd w ld fl mb  ph eb f1 f2 cnt
      vecs.push_back(mk(1,  1,  2, 1, 1,  5, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
      vecs.push_back(mk(1,  5,  6, 1, 1,  8, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 16'd0));
      vecs.push_back(mk(1,  1,  2, 1, 1,  9, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
      vecs.push_back(mk(1,  8,  0, 1, 0, 10, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 16'd0));
      vecs.push_back(mk(1,  1,  0, 1, 0,  7, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0));
      vecs.push_back(mk(1,  3,  7, 1, 1, 11, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0, 16'd1));
      vecs.push_back(mk(1,  3,  7, 1, 1, 11, 1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 16'd1));
      vecs.push_back(mk(1,  2,  0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd1));
      vecs.push_back(mk(1,  0, 11, 1, 0, 12, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd1));
      vecs.push_back(mk(1,  1,  0, 1, 0,  3, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd1));
      vecs.push_back(mk(1,  2,  0, 1, 0,  3, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd1));
      vecs.push_back(mk(1,  3,  3, 1, 1, 13, 1, 0, 0, 0, 0, 0, 2'd1, 2'd1, 16'd1));
      vecs.push_back(mk(1, 13,  0, 1, 0,  3, 1, 1, 0, 0, 0, 0, 2'd1, 2'd0, 16'd1));
      vecs.push_back(mk(1,  3,  0, 1, 0, 14, 1, 0, 0, 1, 0, 0, 2'd1, 2'd0, 16'd1));
      vecs.push_back(mk(1,  3,  0, 1, 0, 14, 1, 0, 0, 1, 0, 0, 2'd1, 2'd0, 16'd1));
      vecs.push_back(mk(1,  3,  0, 1, 0, 14, 1, 0, 0, 1, 0, 0, 2'd1, 2'd0, 16'd1));
      vecs.push_back(mk(1,  3,  0, 1, 0, 14, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0, 16'd2));
      vecs.push_back(mk(1,  3,  0, 1, 0, 14, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 16'd2));
      vecs.push_back(mk(1,  0,  0, 1, 0,  4, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'd2));
      vecs.push_back(mk(1,  4,  0, 1, 0, 15, 1, 0, 1, 0, 0, 1, 2'd0, 2'd0, 16'd2));
      vecs.push_back(mk(1,  4,  0, 1, 0, 16, 1, 0, 0, 0, 0, 0, 2'd2, 2'd0, 16'd2));
      vecs.push_back(mk(1, 16,  0, 1, 0, 17, 1, 0, 1, 1, 0, 0, 2'd2, 2'd0, 16'd2));
      vecs.push_back(mk(1, 16,  0, 1, 0, 17, 1, 0, 0, 0, 0, 0, 2'd1, 2'd0, 16'd2));
      vecs.push_back(mk(0, 17,  0, 1, 0,  5, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'd2));
      vecs.push_back(mk(1,  5, 17, 1, 1, 18, 1, 0, 0, 0, 0, 0, 2'd0, 2'd2, 16'd2));

      // Reset for two cycles with random ID/command inputs.
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         hif.id_valid    = 1'($urandom);
         hif.id_rs1      = 5'($urandom);
         hif.id_rs2      = 5'($urandom);
         hif.id_use_rs1  = 1'($urandom);
         hif.id_use_rs2  = 1'($urandom);
         hif.id_rd       = 5'($urandom);
         hif.id_reg_w_en = 1'($urandom);
         hif.id_is_load  = 1'($urandom);
         hif.flush       = 1'($urandom);
         hif.mem_busy    = 1'($urandom);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      apply_stimulus(idle);
      check_output("reset fwd_rs1_sel", 16'(hif.fwd_rs1_sel), 16'd0);
      check_output("reset fwd_rs2_sel", 16'(hif.fwd_rs2_sel), 16'd0);
      check_output("reset stall_cnt",   hif.stall_cnt,        16'd0);
      run_vec(idle, "post-reset idle");

      for (int i = 0; i < vecs.size(); i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset with a load in EX: the following consumer must not stall.
      run_vec(mk(1, 0, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'd2), "mid load");
      rst_n = 1'b0;
      apply_stimulus(idle);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_output("mid reset stall_cnt", hif.stall_cnt, 16'd0);
      check_output("mid reset fwd_rs1_sel", 16'(hif.fwd_rs1_sel), 16'd0);
      run_vec(mk(1, 0, 7, 0, 1, 19, 1, 0, 0, 0, 0, 0, 2'd0, 2'd0, 16'd0), "after reset consumer");

      // Repeated load-use pairs: 16-bit count keeps going, 4-bit one sticks at 15.
      for (int i = 1; i <= 20; i++) begin
         run_vec(mk(1, 0, 0, 1, 0, 7, 1, 1, 0, 0, 0, 0, 2'd0, 2'd0, 16'(i - 1)),
                 $sformatf("sat load%0d", i));
         run_vec(mk(1, 7, 0, 1, 0, 20, 1, 0, 0, 0, 1, 1, 2'd0, 2'd0, 16'(i)),
                 $sformatf("sat use%0d", i));
         check_output($sformatf("sat cnt%0d", i), 16'(sif.stall_cnt),
                      (i > 15) ? 16'd15 : 16'(i));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end
endmodule
